// File: rtl/airi5c_bus_console_snoop_pkg.sv
// -----------------------------------------------------------------------------
// airi5c_bus_console_snoop_pkg
// Shared definitions for the console snooper:
//   - AHB-Lite HTRANS encodings
//   - ASCII line-feed code used by the optional line buffer
//   - default console channel base and exit-code register addresses
//   - ch_width(): width of a channel index, never narrower than one bit
// -----------------------------------------------------------------------------
package airi5c_bus_console_snoop_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [7:0]  ASCII_LF          = 8'h0A;
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'hC000_0200;
  localparam logic [31:0] DEFAULT_EXIT_ADDR = 32'hC000_0300;

  // A single channel still needs a one-bit index port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/airi5c_console_fifo.sv
// -----------------------------------------------------------------------------
// airi5c_console_fifo
// Synchronous FIFO holding captured console characters.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write data_i; ignored when full unless pop happens too
//   pop_i        : discard the head entry; ignored when empty
//   data_i       : entry to write (WIDTH bits)
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
//   head_o       : oldest entry, valid while !empty_o
// DEPTH must be a power of two, at least 2. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
// -----------------------------------------------------------------------------
module airi5c_console_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees a slot on the same edge, so a push while full is accepted
  // when it coincides with a pop.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  assign head_o = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/airi5c_bus_console_snoop.sv
// -----------------------------------------------------------------------------
// airi5c_bus_console_snoop
// Passive AHB-Lite data-bus snooper. Captures word writes to NUM_CH console
// channels (ADDR_BASE + 4*n) into a FIFO drained over a valid/ready stream,
// captures the first write to EXIT_ADDR as the program exit code, and runs a
// cycle watchdog. It only observes the bus and never drives it.
//
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   haddr_i, htrans_i, hwrite_i, hready_i, hwdata_i : snooped AHB-Lite bus
//   char_valid_o/char_ready_i/char_data_o/char_ch_o : character stream
//   overflow_o       : sticky, a character was dropped on a full FIFO
//   drop_cnt_o       : saturating count of dropped characters
//   exit_valid_o     : sticky, exit code captured
//   exit_code_o      : first exit code written
//   timeout_o        : sticky, watchdog expired (TIMEOUT_CYCLES != 0)
//   cycle_cnt_o      : cycles since reset, wrapping
//
// Build option: define AIRI5C_CONSOLE_LINEBUF_EN to hold the stream back
// until a line feed is buffered (or the FIFO is full).
// -----------------------------------------------------------------------------
module airi5c_bus_console_snoop
  import airi5c_bus_console_snoop_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = DEFAULT_ADDR_BASE,
  parameter int          NUM_CH         = 2,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] EXIT_ADDR      = DEFAULT_EXIT_ADDR,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
  localparam int         CH_W           = ch_width(NUM_CH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     haddr_i,
  input  logic [1:0]      htrans_i,
  input  logic            hwrite_i,
  input  logic            hready_i,
  input  logic [31:0]     hwdata_i,
  output logic            char_valid_o,
  input  logic            char_ready_i,
  output logic [7:0]      char_data_o,
  output logic [CH_W-1:0] char_ch_o,
  output logic            overflow_o,
  output logic [15:0]     drop_cnt_o,
  output logic            exit_valid_o,
  output logic [31:0]     exit_code_o,
  output logic            timeout_o,
  output logic [31:0]     cycle_cnt_o
);

  localparam int          DW      = CH_W + 8;
  localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 32'd1;

  // Address-phase capture
  logic            r_pend_v;
  logic            r_pend_exit;
  logic [CH_W-1:0] r_pend_ch;

  logic            w_ch_hit;
  logic [CH_W-1:0] w_ch_idx;
  logic            w_exit_hit;
  logic            w_qualify;

  // Data-phase / FIFO handshake
  logic            w_complete;
  logic            w_push;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [DW-1:0]   w_head;

  // Status
  logic            w_exit_set;
  logic            w_wd_hit;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;
  logic            r_exit_valid;
  logic [31:0]     r_exit_code;
  logic            r_timeout;
  logic [31:0]     r_cycle_cnt;

  // ---------------------------------------------------------------------------
  // Address decode: exact 32-bit match, so only word-aligned writes hit.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ch_hit = 1'b0;
    w_ch_idx = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (haddr_i == ADDR_BASE + 32'(4 * n)) begin
        w_ch_hit = 1'b1;
        w_ch_idx = CH_W'(n);
      end
    end
  end

  assign w_exit_hit = (haddr_i == EXIT_ADDR);
  assign w_qualify  = hready_i && hwrite_i &&
                      (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ) &&
                      (w_ch_hit || w_exit_hit);

  // Any hready edge both completes the previous data phase and samples a new
  // address phase, which is what makes back-to-back writes work. Wait states
  // leave the pending transfer untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_v    <= 1'b0;
      r_pend_exit <= 1'b0;
      r_pend_ch   <= '0;
    end else if (hready_i) begin
      r_pend_v    <= w_qualify;
      r_pend_exit <= w_exit_hit;
      r_pend_ch   <= w_ch_idx;
    end
  end

  // If EXIT_ADDR aliases a channel address, the exit register wins.
  assign w_complete = r_pend_v && hready_i;
  assign w_push     = w_complete && !r_pend_exit;
  assign w_exit_set = w_complete && r_pend_exit && !r_exit_valid;

  // ---------------------------------------------------------------------------
  // Character FIFO and output stream
  // ---------------------------------------------------------------------------
  airi5c_console_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({r_pend_ch, hwdata_i[7:0]}),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign w_pop     = char_valid_o && char_ready_i;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && !w_push_ok;

`ifdef AIRI5C_CONSOLE_LINEBUF_EN
  localparam int NLW = $clog2(FIFO_DEPTH) + 1;

  logic [NLW-1:0] r_nl_cnt;
  logic           w_nl_in;
  logic           w_nl_out;

  assign w_nl_in  = w_push_ok && (hwdata_i[7:0] == ASCII_LF);
  assign w_nl_out = w_pop && (w_head[7:0] == ASCII_LF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nl_cnt <= '0;
    end else begin
      case ({w_nl_in, w_nl_out})
        2'b10:   r_nl_cnt <= r_nl_cnt + NLW'(1);
        2'b01:   r_nl_cnt <= r_nl_cnt - NLW'(1);
        default: r_nl_cnt <= r_nl_cnt;
      endcase
    end
  end

  // Releasing on full keeps a line longer than the FIFO from deadlocking.
  assign char_valid_o = !w_empty && ((r_nl_cnt != '0) || w_full);
`else
  assign char_valid_o = !w_empty;
`endif

  assign char_data_o = w_head[7:0];
  assign char_ch_o   = w_head[DW-1:8];

  // ---------------------------------------------------------------------------
  // Drop accounting, exit code, watchdog, cycle counter
  // ---------------------------------------------------------------------------
  // Timeout fires on the edge the counter becomes TIMEOUT_CYCLES-1; an exit
  // captured on that same edge wins.
  assign w_wd_hit = (TIMEOUT_CYCLES != 32'd0) &&
                    (r_cycle_cnt + 32'd1 == WD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
      r_exit_valid <= 1'b0;
      r_exit_code  <= '0;
      r_timeout    <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_exit_set) begin
        r_exit_valid <= 1'b1;
        r_exit_code  <= hwdata_i;
      end
      if (w_wd_hit && !r_exit_valid && !w_exit_set) r_timeout <= 1'b1;
    end
  end

  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_drop_cnt;
  assign exit_valid_o = r_exit_valid;
  assign exit_code_o  = r_exit_code;
  assign timeout_o    = r_timeout;
  assign cycle_cnt_o  = r_cycle_cnt;

endmodule

// File: doc/airi5c_bus_console_snoop.md
Name: airi5c_bus_console_snoop

Overview:
- Passive AHB-Lite (HASTI) data-bus snooper that captures the core's console writes on NUM_CH memory-mapped channels.
- Buffers the captured characters in a FIFO and drains them through a valid/ready stream to a host printer or UART model.
- Also captures a program exit code and runs a cycle watchdog.
- Sits beside the core's dmem port in bench and emulation configs. It never drives the bus.

Parameters:
- ADDR_BASE, 32'hC000_0200: address of channel 0. Channel n is at ADDR_BASE + 4*n.
- NUM_CH, 2: number of console channels, 1..8.
- FIFO_DEPTH, 16: number of character entries. Must be a power of 2, minimum 2.
- EXIT_ADDR, 32'hC000_0300: address of the exit-code register.
- TIMEOUT_CYCLES, 0: watchdog limit in cycles. 0 disables the watchdog.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: asynchronous, active-high reset.
- haddr_i, input, 32: snooped HADDR.
- htrans_i, input, 2: snooped HTRANS.
- hwrite_i, input, 1: snooped HWRITE.
- hready_i, input, 1: snooped HREADY.
- hwdata_i, input, 32: snooped HWDATA.
- char_valid_o, output, 1: character available on the output stream.
- char_ready_i, input, 1: consumer accepts the character.
- char_data_o, output, 8: character byte.
- char_ch_o, output, CH_W: source channel. CH_W = max(1, clog2(NUM_CH)).
- overflow_o, output, 1: sticky flag, at least one character was dropped.
- drop_cnt_o, output, 16: saturating count of dropped characters.
- exit_valid_o, output, 1: sticky flag, exit code captured.
- exit_code_o, output, 32: captured exit code.
- timeout_o, output, 1: sticky flag, watchdog expired.
- cycle_cnt_o, output, 32: cycles since reset, wrapping.

Behaviour:
- Reset: all outputs are 0; FIFO is empty; the address-phase register is cleared. Assertion of rst_i mid-transfer discards any pending data phase and all FIFO contents.
- Address phase: a transfer is qualified when all of the following hold on a rising edge:
  - hready_i = 1;
  - htrans_i is NONSEQ (2'b10) or SEQ (2'b11);
  - hwrite_i = 1;
  - haddr_i matches a channel address or EXIT_ADDR.
  A qualified transfer registers pend_v, pend_ch and pend_exit.
- Data phase: completes on the first later edge with hready_i = 1. Wait states (hready_i = 0) hold the pending state. On completion:
  - channel write: push {ch, hwdata_i[7:0]};
  - exit write: capture hwdata_i.
- Back-to-back pipelined writes must capture both transfers: a new address phase and the completing data phase occur on the same edge.
- Channel match: exact 32-bit compare, so word aligned only. IDLE and BUSY transfers and reads are ignored.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs are equal.
- Push and pop:
  - push when full without a pop: the character is dropped, overflow_o is set, and drop_cnt_o increments, saturating at 16'hFFFF;
  - push and pop on the same edge while full: both occur, nothing is dropped;
  - push when empty: char_valid_o rises on the next cycle, with no combinational bypass.
- Output stream: char_valid_o = !empty and char_data_o/char_ch_o are taken from the head entry. The head holds stable while valid && !ready. Pop happens on valid && ready.
- Exit register: the first exit write sets exit_valid_o and exit_code_o. Later exit writes are ignored until reset. Console capture continues after exit.
- Watchdog, when TIMEOUT_CYCLES != 0: timeout_o is set on the edge where cycle_cnt_o reaches TIMEOUT_CYCLES - 1 while exit_valid_o = 0. timeout_o is sticky. An exit on that same edge takes priority and suppresses the timeout.

Optional Feature:
- Macro AIRI5C_CONSOLE_LINEBUF_EN.
- Defined: the output is line-buffered. char_valid_o is asserted only when all of these hold:
  - !empty;
  - nl_cnt > 0 or full. nl_cnt counts 8'h0A entries in the FIFO and is incremented on push of 0x0A and decremented on pop of 0x0A; same-edge push and pop of 0x0A leave it unchanged.
  - The full condition prevents deadlock on long lines.
- Undefined: character-by-character streaming as described above, and no nl_cnt logic.

Decomposition:
- Shared header airi5c_console_constants.vh holds:
  - HTRANS encodings (reuse the hasti constants where present);
  - ASCII_LF = 8'h0A;
  - default ADDR_BASE and EXIT_ADDR;
  - the CH_W computation macro.
- Sub-module airi5c_console_fifo: parametrised WIDTH/DEPTH synchronous FIFO with push, pop, full, empty and head outputs. The optional newline counter lives in the top module.

Test Plan:
- Write 0x41 to 32'hC0000200, with no wait state and char_ready_i = 1: char_valid_o is high on cycle 2 after the address phase with data 0x41, ch 0, for one cycle.
- Back-to-back NONSEQ writes 'H' to ch0 and 'i' to ch1 (0xC0000204), with 2 wait states on the second: stream delivers H/0 then i/1 in order, with nothing lost.
- char_ready_i = 0 and 20 writes with FIFO_DEPTH 16: 16 entries are held, overflow_o = 1, drop_cnt_o = 4; then ready = 1 drains the first 16 characters in order.
- Writes to EXIT_ADDR of 0x1 then 0x2: exit_valid_o = 1 and exit_code_o = 0x1. A read of 0xC0000200 and an IDLE transfer with that address produce no push.
- TIMEOUT_CYCLES = 100 with no exit: timeout_o rises on the edge where cycle_cnt_o becomes 99. Rerun with the exit written at cycle 99: timeout_o stays 0.
- LINEBUF_EN defined: write "ab" and char_valid_o stays 0; write 0x0A and 'a', 'b', LF drain; with 16 non-LF writes, draining starts on full.
